// File: rtl/systolic_mm_engine.sv
// rtl/systolic_mm_engine.sv - output-stationary ROWS x COLS systolic matrix multiply engine
// Streams un-skewed A columns / B rows, accumulates C = A x B in place, then reads C out row by row.
module systolic_mm_engine #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int DW   = 8,
  parameter int AW   = 32,
  parameter int KMAX = 256
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [$clog2(KMAX+1)-1:0]          k_len,
  input  logic                               signed_mode,
  input  logic                               op_valid,
  output logic                               op_ready,
  input  logic [ROWS*DW-1:0]                 a_in,
  input  logic [COLS*DW-1:0]                 b_in,
  output logic                               busy,
  output logic                               done,
  output logic                               rd_valid,
  input  logic                               rd_ready,
  output logic [COLS*AW-1:0]                 rd_data,
  output logic [((ROWS>1)?$clog2(ROWS):1)-1:0] rd_row
);
  localparam int KW = $clog2(KMAX + 1);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int FN = ROWS + COLS - 2;
  localparam int FW = (FN > 0) ? $clog2(FN + 1) : 1;
  localparam int CW = (KW > FW) ? KW : FW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] row_q, row_d;
  logic          sm_q, sm_d;
  logic          done_q, done_d;
  logic          clr, adv;

  logic [DW-1:0] a_tap [ROWS][COLS];
  logic [DW-1:0] b_tap [ROWS][COLS];
  logic [AW-1:0] inc   [ROWS][COLS];
  logic [AW-1:0] acc_q [ROWS][COLS];
  logic [AW-1:0] acc_d [ROWS][COLS];

  assign clr = (state_q == S_IDLE) && start;
  // Global clock-enable: the whole array only moves on an operand handshake or while flushing.
  assign adv = ((state_q == S_LOAD) && op_valid) || (state_q == S_FLUSH);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    row_d   = row_q;
    sm_d    = sm_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sm_d  = signed_mode;
          row_d = '0;
          if (k_len != '0) begin
            state_d = S_LOAD;
            cnt_d   = CW'(k_len);
          end else if (FN > 0) begin
            state_d = S_FLUSH;
            cnt_d   = CW'(FN);
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_LOAD: begin
        if (op_valid) begin
          if (cnt_q == CW'(1)) begin
            state_d = (FN > 0) ? S_FLUSH : S_DRAIN;
            cnt_d   = CW'(FN);
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q == CW'(1)) state_d = S_DRAIN;
        else cnt_d = cnt_q - CW'(1);
      end
      default: begin
        if (rd_ready) begin
          if (row_q == RW'(ROWS - 1)) begin
            state_d = S_IDLE;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      sm_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      sm_q    <= sm_d;
      done_q  <= done_d;
    end
  end

  // Row i's chain doubles as input skew and inter-PE pipe: PE(i,j) taps a_in delayed i+j steps.
  for (genvar i = 0; i < ROWS; i++) begin : g_arow
    localparam int D = i + COLS - 1;
    logic [DW-1:0] a_src;
    assign a_src = (state_q == S_LOAD) ? a_in[i*DW +: DW] : '0;
    if (D > 0) begin : g_sr
      logic [DW-1:0] sr_q [D];
      logic [DW-1:0] sr_d [D];
      always_comb begin
        for (int s = 0; s < D; s++) sr_d[s] = sr_q[s];
        if (clr) begin
          for (int s = 0; s < D; s++) sr_d[s] = '0;
        end else if (adv) begin
          sr_d[0] = a_src;
          for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
        end
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) for (int s = 0; s < D; s++) sr_q[s] <= '0;
        else        for (int s = 0; s < D; s++) sr_q[s] <= sr_d[s];
      end
      for (genvar j = 0; j < COLS; j++) begin : g_tap
        if (i + j == 0) begin : g_direct
          assign a_tap[i][j] = a_src;
        end else begin : g_delayed
          assign a_tap[i][j] = sr_q[i+j-1];
        end
      end
    end else begin : g_nosr
      assign a_tap[i][0] = a_src;
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_bcol
    localparam int D = j + ROWS - 1;
    logic [DW-1:0] b_src;
    assign b_src = (state_q == S_LOAD) ? b_in[j*DW +: DW] : '0;
    if (D > 0) begin : g_sr
      logic [DW-1:0] sr_q [D];
      logic [DW-1:0] sr_d [D];
      always_comb begin
        for (int s = 0; s < D; s++) sr_d[s] = sr_q[s];
        if (clr) begin
          for (int s = 0; s < D; s++) sr_d[s] = '0;
        end else if (adv) begin
          sr_d[0] = b_src;
          for (int s = 1; s < D; s++) sr_d[s] = sr_q[s-1];
        end
      end
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) for (int s = 0; s < D; s++) sr_q[s] <= '0;
        else        for (int s = 0; s < D; s++) sr_q[s] <= sr_d[s];
      end
      for (genvar i = 0; i < ROWS; i++) begin : g_tap
        if (i + j == 0) begin : g_direct
          assign b_tap[i][j] = b_src;
        end else begin : g_delayed
          assign b_tap[i][j] = sr_q[i+j-1];
        end
      end
    end else begin : g_nosr
      assign b_tap[0][j] = b_src;
    end
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_pr
    for (genvar j = 0; j < COLS; j++) begin : g_pc
      logic signed [2*DW-1:0] prod_s;
      logic [2*DW-1:0]        prod_u;
      assign prod_s = $signed({{DW{a_tap[i][j][DW-1]}}, a_tap[i][j]}) *
                      $signed({{DW{b_tap[i][j][DW-1]}}, b_tap[i][j]});
      assign prod_u = {{DW{1'b0}}, a_tap[i][j]} * {{DW{1'b0}}, b_tap[i][j]};
      assign inc[i][j] = sm_q ? AW'(prod_s) : AW'(prod_u);
    end
  end

  always_comb begin
    for (int i = 0; i < ROWS; i++) begin
      for (int j = 0; j < COLS; j++) begin
        acc_d[i][j] = acc_q[i][j];
        if (clr)      acc_d[i][j] = '0;
        else if (adv) acc_d[i][j] = acc_q[i][j] + inc[i][j];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_q[i][j] <= '0;
    end else begin
      for (int i = 0; i < ROWS; i++)
        for (int j = 0; j < COLS; j++) acc_q[i][j] <= acc_d[i][j];
    end
  end

  assign op_ready = (state_q == S_LOAD);
  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign rd_valid = (state_q == S_DRAIN);
  assign rd_row   = row_q;

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < COLS; j++) begin
      if (rd_valid) rd_data[j*AW +: AW] = acc_q[row_q][j];
    end
  end
endmodule

// File: tb/tb_systolic_mm_engine.sv
// tb/tb_systolic_mm_engine.sv - scoreboard bench for systolic_mm_engine
// Driver pushes model rows per multiply; monitor pops and compares on every accepted result beat.
module tb_systolic_mm_engine;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int DW   = 8;
  localparam int AW   = 32;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);

  typedef logic [C*AW-1:0] row_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [KW-1:0] k_len = '0;
  logic          signed_mode = 1'b0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [R*DW-1:0] a_in = '0;
  logic [C*DW-1:0] b_in = '0;
  logic          busy, done, rd_valid;
  logic          rd_ready = 1'b1;
  row_t          rd_data;
  logic [1:0]    rd_row;

  always #5 clk = ~clk;

  systolic_mm_engine #(.ROWS(R), .COLS(C), .DW(DW), .AW(AW), .KMAX(KMAX)) u_dut (
    .clk(clk), .reset(reset), .start(start), .k_len(k_len), .signed_mode(signed_mode),
    .op_valid(op_valid), .op_ready(op_ready), .a_in(a_in), .b_in(b_in),
    .busy(busy), .done(done), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_row(rd_row)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   a_m [R][KMAX];
  int   b_m [KMAX][C];
  row_t exp_q [$];
  int   exp_row_q [$];
  int   first_cyc, done_cyc, done_cnt;
  bit   first_arm = 1'b0;

  task automatic chk(input string name, input row_t got, input row_t exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic longint opv(input int v, input bit sm);
    return (sm && v >= 128) ? longint'(v - 256) : longint'(v);
  endfunction

  // Reference: plain dot products, truncated to the accumulator width.
  task automatic push_expected(input int k, input bit sm);
    row_t   row;
    longint s;
    for (int i = 0; i < R; i++) begin
      row = '0;
      for (int j = 0; j < C; j++) begin
        s = 0;
        for (int kk = 0; kk < k; kk++) s += opv(a_m[i][kk], sm) * opv(b_m[kk][j], sm);
        row[j*AW +: AW] = s[AW-1:0];
      end
      exp_q.push_back(row);
      exp_row_q.push_back(i);
    end
  endtask

  // mode 0 identity, 1 constants, 2 a=i+k b=k+j, 3 random
  task automatic fill(input int mode, input int va, input int vb);
    for (int k = 0; k < KMAX; k++) begin
      for (int i = 0; i < R; i++)
        a_m[i][k] = (mode == 0) ? int'(i == k) : (mode == 1) ? va : (mode == 2) ? i + k : int'($urandom_range(0, 255));
      for (int j = 0; j < C; j++)
        b_m[k][j] = (mode == 0) ? int'(k == j) : (mode == 1) ? vb : (mode == 2) ? k + j : int'($urandom_range(0, 255));
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (first_arm && rd_valid) begin
        first_cyc = cyc;
        first_arm = 1'b0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (rd_valid) chk("op_ready_in_drain", row_t'(op_ready), row_t'(0));
      if (rd_valid && !rd_ready && exp_q.size() > 0) begin
        chk("hold_data", rd_data, exp_q[0]);
        chk("hold_row", row_t'(rd_row), row_t'(exp_row_q[0]));
      end
      if (rd_valid && rd_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", row_t'(1), row_t'(0));
        end else begin
          chk("row_data", rd_data, exp_q.pop_front());
          chk("row_index", row_t'(rd_row), row_t'(exp_row_q.pop_front()));
        end
      end
    end
  end

  task automatic run_mm(input int k, input bit sm, input bit gaps, input bit rd_stall,
                        input bit inj_start, input bit chk_lat);
    int s_cyc, guard;
    bit rdy;
    push_expected(k, sm);
    done_cnt  = 0;
    first_arm = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(k); signed_mode = sm;
    @(posedge clk); #1;
    start = 1'b0; s_cyc = cyc;
    k_len = KW'($urandom); signed_mode = 1'($urandom);
    for (int kk = 0; kk < k; kk++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          op_valid = 1'b0; a_in = $urandom; b_in = $urandom;
          @(posedge clk); #1;
        end
      end
      op_valid = 1'b1;
      for (int i = 0; i < R; i++) a_in[i*DW +: DW] = DW'(a_m[i][kk]);
      for (int j = 0; j < C; j++) b_in[j*DW +: DW] = DW'(b_m[kk][j]);
      if (inj_start && kk == 1) begin
        start = 1'b1; k_len = KW'(1);
      end
      guard = 0;
      do begin
        @(negedge clk); rdy = op_ready;
        @(posedge clk); #1;
        start = 1'b0; guard++;
      end while (!rdy && guard < 100);
      if (!rdy) chk("op_ready_timeout", row_t'(rdy), row_t'(1));
    end
    op_valid = 1'b0;
    chk("op_ready_after_load", row_t'(op_ready), row_t'(0));
    chk("busy_after_load", row_t'(busy), row_t'(1));
    if (rd_stall) begin
      guard = 0;
      do begin @(negedge clk); guard++; end while (!rd_valid && guard < 500);
      @(posedge clk); #1;
      rd_ready = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rd_ready = 1'b1;
    end
    guard = 0;
    while (done_cnt == 0 && guard < 2000) begin @(negedge clk); guard++; end
    repeat (3) @(negedge clk);
    chk("done_pulses", row_t'(done_cnt), row_t'(1));
    chk("rows_left", row_t'(exp_q.size()), row_t'(0));
    chk("busy_after_done", row_t'(busy), row_t'(0));
    if (chk_lat) begin
      chk("first_valid_latency", row_t'(first_cyc - s_cyc), row_t'(k + R + C - 2));
      chk("done_latency", row_t'(done_cyc - first_cyc), row_t'(R));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    chk("rst_op_ready", row_t'(op_ready), row_t'(0));
    chk("rst_busy", row_t'(busy), row_t'(0));
    chk("rst_done", row_t'(done), row_t'(0));
    chk("rst_rd_valid", row_t'(rd_valid), row_t'(0));
    chk("rst_rd_row", row_t'(rd_row), row_t'(0));
    chk("rst_rd_data", rd_data, row_t'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    fill(0, 0, 0);   run_mm(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(1, 253, 5); run_mm(4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(1, 253, 5); run_mm(4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(2, 0, 0);   run_mm(6, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    fill(3, 0, 0);   run_mm(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    fill(1, 255, 255); run_mm(256, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      fill(3, 0, 0);
      run_mm($urandom_range(1, 12), 1'($urandom), 1'b1, 1'($urandom), 1'b0, 1'b0);
    end

    // Abort during FLUSH: outputs drop at once and no done follows.
    fill(3, 0, 0);
    done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; k_len = KW'(3); signed_mode = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; op_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    op_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("abort_op_ready", row_t'(op_ready), row_t'(0));
    chk("abort_busy", row_t'(busy), row_t'(0));
    chk("abort_done", row_t'(done), row_t'(0));
    chk("abort_rd_valid", row_t'(rd_valid), row_t'(0));
    chk("abort_rd_row", row_t'(rd_row), row_t'(0));
    chk("abort_rd_data", rd_data, row_t'(0));
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (15) @(negedge clk);
    chk("abort_no_done", row_t'(done_cnt), row_t'(0));
    chk("abort_idle", row_t'(busy), row_t'(0));

    fill(3, 0, 0);   run_mm(2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/systolic_mm_engine.md
Name: systolic_mm_engine

Overview:
- Parametrised successor to the 4x4 8-bit MAC array: ROWS x COLS output-stationary systolic grid with generic operand/accumulator widths and a signed/unsigned mode.
- Adds internal input skewing, a sequencing FSM (load, flush, drain) and a valid/ready result readout, so upstream logic streams un-skewed operands and receives the finished C = A x B one row per beat.
- Sits between the operand buffers and the result write-back path of the matrix processor.

Parameters:
- ROWS, 4, number of array rows (rows of A and C).
- COLS, 4, number of array columns (columns of B and C).
- DW, 8, operand width in bits.
- AW, 32, accumulator width in bits (AW >= 2*DW).
- KMAX, 256, maximum inner dimension K.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a multiply; sampled in IDLE only.
- k_len  in  $clog2(KMAX+1)  inner dimension K, captured on accepted start.
- signed_mode  in  1  1 = two's-complement operands; captured on accepted start.
- op_valid  in  1  a_in/b_in hold beat k of the operand stream.
- op_ready  out  1  engine accepts an operand beat this cycle.
- a_in  in  ROWS*DW  column k of A; element i in bits [i*DW +: DW].
- b_in  in  COLS*DW  row k of B; element j in bits [j*DW +: DW].
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last result beat is accepted.
- rd_valid  out  1  rd_data holds a C row.
- rd_ready  in  1  downstream accepts the row.
- rd_data  out  COLS*AW  C[rd_row][j] in bits [j*AW +: AW].
- rd_row  out  $clog2(ROWS) (min 1)  index of the row on rd_data.

Behaviour:
- Reset (reset low, asynchronous): FSM to IDLE; all accumulators, skew registers and inter-PE operand registers cleared; op_ready=0, busy=0, done=0, rd_valid=0, rd_row=0, rd_data=0. Asserting reset mid-operation aborts with no done pulse.
- IDLE: start=1 latches k_len and signed_mode, clears all accumulators and the beat counter, then goes to LOAD, or to FLUSH if k_len==0. start while busy is ignored.
- LOAD: op_ready=1. A handshake (op_valid & op_ready) advances the whole array by one step: skew registers shift, PEs multiply-accumulate, operands propagate right/down. Without a handshake the array holds (global clock-enable, no bubbles inserted). Row i of A is delayed i stages and column j of B is delayed j stages. After beat k_len-1 go to FLUSH.
- FLUSH: op_ready=0. The array advances every cycle with zero operands injected, for exactly ROWS+COLS-2 cycles (counter), so that PE(i,j) has summed k=0..K-1. Then go to DRAIN.
- DRAIN: rd_valid=1, rd_row starts at 0, rd_data = accumulator row rd_row. On rd_valid & rd_ready, rd_row increments. On the beat for row ROWS-1, go to IDLE and pulse done for one cycle. rd_data and rd_row stay stable while rd_valid=1 and rd_ready=0.
- Arithmetic: product is the full 2*DW bits, signed or unsigned per the captured mode. It is sign- or zero-extended to AW and added modulo 2^AW (wrap, no saturation).
- Latency with op_valid held high and rd_ready held high: first rd_valid K+ROWS+COLS-2 cycles after leaving IDLE; done ROWS cycles after that.
- k_len > KMAX is truncated by the port width and not otherwise checked.

Test Plan:
- 4x4 unsigned: A = B = identity, K=4, op_valid and rd_ready held high -> rows read out as identity (1 on the diagonal, 0 elsewhere); rd_valid first at cycle 10 after start; done one cycle after row 3 is accepted.
- Signed: signed_mode=1, all A=-3 (0xFD), all B=5, K=4 -> every C element = -60 (0xFFFFFFC4). Repeat with signed_mode=0 -> every C element = 4*253*5 = 5060.
- Stalls: random op_valid gaps and rd_ready deasserted for 3 cycles mid-DRAIN, A[i][k]=i+k, B[k][j]=k+j, K=6 -> C matches the reference model. rd_data and rd_row are held during backpressure; op_ready stays 0 outside LOAD.
- K=0 -> goes straight to FLUSH then DRAIN; all 4 rows read out as 0; done pulses. Also: start issued during LOAD is ignored and the result is unchanged.
- Overflow: unsigned A = B = 255, K = KMAX = 256 -> every C element = 16646400 (no wrap at AW=32). Re-run with AW=16 -> every C element = 16646400 mod 65536 = 0x0100.
- Reset asserted during FLUSH -> all outputs 0 immediately (asynchronous), no done pulse. A following clean 2x2 run (ROWS=COLS=2, K=2) produces correct results.
